board_ram_arbiter: RTL and testbench

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

---
 rtl/board_ram_arbiter_pkg.sv | 26 ++
 rtl/board_ram_arbiter_if.sv | 48 ++++
 rtl/board_clear_seq.sv | 61 ++++++
 rtl/board_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_board_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_ram_arbiter_pkg.sv
// rtl/board_ram_arbiter_pkg.sv - shared cell codes, board geometry defaults and owner tag type
package board_ram_arbiter_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int HEIGHT_DEF = 16;
   localparam int X_W        = 5;
   localparam int Y_W        = 4;
   localparam int D_W        = 4;

   typedef enum logic [D_W-1:0] {
      CELL_EMPTY = 4'd0,
      CELL_RIGHT = 4'd1,
      CELL_UP    = 4'd2,
      CELL_LEFT  = 4'd4,
      CELL_DOWN  = 4'd8,
      CELL_APPLE = 4'd15
   } cell_t;

   // Which port owns the RAM read data coming back next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_GAME = 2'd1,
      OWN_DISP = 2'd2
   } owner_t;

endpackage

// File: rtl/board_ram_arbiter_if.sv
// rtl/board_ram_arbiter_if.sv - game, display and RAM bus bundle with requester/arbiter modports
interface board_ram_arbiter_if;
   import board_ram_arbiter_pkg::*;

   logic           game_req;
   logic           game_we;
   logic [X_W-1:0] game_x;
   logic [Y_W-1:0] game_y;
   logic [D_W-1:0] game_wdata;
   logic           game_gnt;
   logic           game_rvalid;
   logic [D_W-1:0] game_rdata;

   logic           disp_req;
   logic [X_W-1:0] disp_x;
   logic [Y_W-1:0] disp_y;
   logic           disp_gnt;
   logic           disp_rvalid;
   logic [D_W-1:0] disp_rdata;

   logic [X_W-1:0] mem_x;
   logic [Y_W-1:0] mem_y;
   logic           mem_rd;
   logic           mem_wr;
   logic [D_W-1:0] mem_wdata;
   logic [D_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  game_req, game_we, game_x, game_y, game_wdata,
      output game_gnt, game_rvalid, game_rdata,
      input  disp_req, disp_x, disp_y,
      output disp_gnt, disp_rvalid, disp_rdata,
      output mem_x, mem_y, mem_rd, mem_wr, mem_wdata,
      input  mem_rdata
   );

   // Requesters plus RAM side
   modport master (
      output game_req, game_we, game_x, game_y, game_wdata,
      input  game_gnt, game_rvalid, game_rdata,
      output disp_req, disp_x, disp_y,
      input  disp_gnt, disp_rvalid, disp_rdata,
      input  mem_x, mem_y, mem_rd, mem_wr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/board_clear_seq.sv
// rtl/board_clear_seq.sv - row-major x/y sweep counter with busy flag for the board wipe
module board_clear_seq
   import board_ram_arbiter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   output logic           busy_o,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o
);

   logic           busy_q, busy_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;

   // Start only when idle; walk x first, then y, drop busy after the last cell
   always_comb begin
      busy_d = busy_q;
      x_d    = x_q;
      y_d    = y_q;
      if (!busy_q) begin
         if (start_i) begin
            busy_d = 1'b1;
            x_d    = '0;
            y_d    = '0;
         end
      end else if (x_q == X_W'(WIDTH - 1)) begin
         x_d = '0;
         if (y_q == Y_W'(HEIGHT - 1)) begin
            busy_d = 1'b0;
            y_d    = '0;
         end else begin
            y_d = y_q + 1'b1;
         end
      end else begin
         x_d = x_q + 1'b1;
      end
   end

   // Sweep state register; reset aborts any wipe in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         busy_q <= busy_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

   assign busy_o = busy_q;
   assign x_o    = x_q;
   assign y_o    = y_q;

endmodule

// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - single-port board RAM arbiter, display priority with game anti-starvation; optional wipe under BOARD_ARB_CLEAR_EN
module board_ram_arbiter
   import board_ram_arbiter_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEF,
   parameter int HEIGHT        = HEIGHT_DEF,
   parameter int GAME_MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_start,
   output logic                clear_busy,
   board_ram_arbiter_if.slave  bus
);

   localparam int WAIT_W = $clog2(GAME_MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_q, wait_d;
   owner_t            owner_q, owner_d;
   logic [X_W-1:0]    addr_x_q, addr_x_d;
   logic [Y_W-1:0]    addr_y_q, addr_y_d;
   logic              game_win;

   logic              wipe_busy;
   logic [X_W-1:0]    wipe_x;
   logic [Y_W-1:0]    wipe_y;

`ifdef BOARD_ARB_CLEAR_EN
   board_clear_seq #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_clear (
      .clk     (clk),
      .rst     (rst),
      .start_i (clear_start),
      .busy_o  (wipe_busy),
      .x_o     (wipe_x),
      .y_o     (wipe_y)
   );
`else
   localparam int unused_cells = WIDTH * HEIGHT;
   logic unused_clear_start;
   assign unused_clear_start = clear_start;
   assign wipe_busy = 1'b0;
   assign wipe_x    = '0;
   assign wipe_y    = '0;
`endif

   assign clear_busy = wipe_busy;

   // Pick this cycle's single RAM access: reset, wipe, starved game, display, game
   always_comb begin
      bus.game_gnt  = 1'b0;
      bus.disp_gnt  = 1'b0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_wdata = '0;
      addr_x_d      = addr_x_q;
      addr_y_d      = addr_y_q;
      owner_d       = OWN_NONE;
      game_win      = bus.game_req &&
                      (!bus.disp_req || wait_q == WAIT_W'(GAME_MAX_WAIT));
      if (!rst) begin
         owner_d = OWN_NONE;
      end else if (wipe_busy) begin
         bus.mem_wr    = 1'b1;
         bus.mem_wdata = CELL_EMPTY;
         addr_x_d      = wipe_x;
         addr_y_d      = wipe_y;
      end else if (game_win) begin
         bus.game_gnt = 1'b1;
         addr_x_d     = bus.game_x;
         addr_y_d     = bus.game_y;
         if (bus.game_we) begin
            bus.mem_wr    = 1'b1;
            bus.mem_wdata = bus.game_wdata;
         end else begin
            bus.mem_rd = 1'b1;
            owner_d    = OWN_GAME;
         end
      end else if (bus.disp_req) begin
         bus.disp_gnt = 1'b1;
         bus.mem_rd   = 1'b1;
         addr_x_d     = bus.disp_x;
         addr_y_d     = bus.disp_y;
         owner_d      = OWN_DISP;
      end
   end

   assign bus.mem_x = addr_x_d;
   assign bus.mem_y = addr_y_d;

   // Game wait counter: count ungranted cycles, saturate, clear on grant or idle
   always_comb begin
      wait_d = wait_q;
      if (!bus.game_req || bus.game_gnt) begin
         wait_d = '0;
      end else if (wait_q != WAIT_W'(GAME_MAX_WAIT)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // Arbiter state: wait counter, read-owner tag and last RAM address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q   <= '0;
         owner_q  <= OWN_NONE;
         addr_x_q <= '0;
         addr_y_q <= '0;
      end else begin
         wait_q   <= wait_d;
         owner_q  <= owner_d;
         addr_x_q <= addr_x_d;
         addr_y_q <= addr_y_d;
      end
   end

   assign bus.game_rvalid = (owner_q == OWN_GAME);
   assign bus.disp_rvalid = (owner_q == OWN_DISP);
   assign bus.game_rdata  = bus.game_rvalid ? bus.mem_rdata : '0;
   assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - directed self-checking bench for board_ram_arbiter
module tb_board_ram_arbiter;

   logic clk;
   logic rst;
   logic clear_start;
   logic clear_busy;

   int checks;
   int errors;

   logic [3:0] ram [0:511];

   board_ram_arbiter_if bus ();

   board_ram_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write on the edge, read data valid one cycle after mem_rd
   always @(posedge clk) begin
      if (bus.mem_wr) ram[{bus.mem_y, bus.mem_x}] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= ram[{bus.mem_y, bus.mem_x}];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic game_drive(input logic req, input logic we, input logic [4:0] x,
                             input logic [3:0] y, input logic [3:0] wd);
      bus.game_req   = req;
      bus.game_we    = we;
      bus.game_x     = x;
      bus.game_y     = y;
      bus.game_wdata = wd;
   endtask

   task automatic disp_drive(input logic req, input logic [4:0] x, input logic [3:0] y);
      bus.disp_req = req;
      bus.disp_x   = x;
      bus.disp_y   = y;
   endtask

   int busy_cycles;
   int gnt_seen;
   bit done;

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 512; i++) ram[i] = 4'h0;
      rst         = 1'b0;
      clear_start = 1'b0;
      game_drive(1'b1, 1'b0, 5'd7, 4'd3, 4'h0);
      disp_drive(1'b1, 5'd2, 4'd1);

      // Reset state with both requests high
      repeat (2) @(negedge clk);
      #1;
      check("rst_game_gnt", bus.game_gnt, 0);
      check("rst_disp_gnt", bus.disp_gnt, 0);
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_mem_x", bus.mem_x, 0);
      check("rst_mem_y", bus.mem_y, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_game_rvalid", bus.game_rvalid, 0);
      check("rst_disp_rvalid", bus.disp_rvalid, 0);
      check("rst_game_rdata", bus.game_rdata, 0);
      check("rst_clear_busy", clear_busy, 0);

      // Write APPLE to (3,9) right at reset release
      @(negedge clk);
      rst = 1'b1;
      disp_drive(1'b0, 5'd0, 4'd0);
      game_drive(1'b1, 1'b1, 5'd3, 4'd9, 4'hF);
      #1;
      check("wr_game_gnt", bus.game_gnt, 1);
      check("wr_mem_wr", bus.mem_wr, 1);
      check("wr_mem_rd", bus.mem_rd, 0);
      check("wr_mem_x", bus.mem_x, 3);
      check("wr_mem_y", bus.mem_y, 9);
      check("wr_mem_wdata", bus.mem_wdata, 4'hF);

      // Read it back
      @(negedge clk);
      game_drive(1'b1, 1'b0, 5'd3, 4'd9, 4'h0);
      #1;
      check("rd_game_gnt", bus.game_gnt, 1);
      check("rd_mem_rd", bus.mem_rd, 1);
      check("rd_mem_wr", bus.mem_wr, 0);
      check("wr_no_rvalid", bus.game_rvalid, 0);

      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      #1;
      check("rd_game_rvalid", bus.game_rvalid, 1);
      check("rd_game_rdata", bus.game_rdata, 4'hF);
      check("rd_disp_rvalid", bus.disp_rvalid, 0);
      check("idle_mem_rd", bus.mem_rd, 0);
      check("idle_mem_wr", bus.mem_wr, 0);
      check("idle_mem_x_hold", bus.mem_x, 3);
      check("idle_mem_y_hold", bus.mem_y, 9);

      // Seed (1,9)=LEFT and (0,0)=DOWN
      @(negedge clk);
      game_drive(1'b1, 1'b1, 5'd1, 4'd9, 4'h4);
      @(negedge clk);
      game_drive(1'b1, 1'b1, 5'd0, 4'd0, 4'h8);

      // Simultaneous requests: display first, then game
      @(negedge clk);
      game_drive(1'b1, 1'b0, 5'd1, 4'd9, 4'h0);
      disp_drive(1'b1, 5'd0, 4'd0);
      #1;
      check("sim_disp_gnt", bus.disp_gnt, 1);
      check("sim_game_gnt0", bus.game_gnt, 0);
      check("sim_mem_x0", bus.mem_x, 0);
      check("sim_mem_y0", bus.mem_y, 0);

      @(negedge clk);
      disp_drive(1'b0, 5'd0, 4'd0);
      #1;
      check("sim_game_gnt1", bus.game_gnt, 1);
      check("sim_mem_x1", bus.mem_x, 1);
      check("sim_disp_rvalid", bus.disp_rvalid, 1);
      check("sim_disp_rdata", bus.disp_rdata, 4'h8);
      check("sim_game_rvalid0", bus.game_rvalid, 0);

      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      #1;
      check("sim_game_rvalid", bus.game_rvalid, 1);
      check("sim_game_rdata", bus.game_rdata, 4'h4);
      check("sim_disp_rvalid1", bus.disp_rvalid, 0);

      // Starvation: display held continuously, game wins on the 5th cycle
      @(negedge clk);
      game_drive(1'b1, 1'b0, 5'd3, 4'd9, 4'h0);
      disp_drive(1'b1, 5'd1, 4'd9);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (c <= 4) begin
            check($sformatf("starve_disp_gnt_c%0d", c), bus.disp_gnt, 1);
            check($sformatf("starve_game_gnt_c%0d", c), bus.game_gnt, 0);
         end else if (c == 5) begin
            check("starve_game_gnt_c5", bus.game_gnt, 1);
            check("starve_disp_gnt_c5", bus.disp_gnt, 0);
            check("starve_disp_rdata_c5", bus.disp_rdata, 4'h4);
         end else begin
            check("starve_disp_gnt_c6", bus.disp_gnt, 1);
            check("starve_game_gnt_c6", bus.game_gnt, 0);
            check("starve_game_rvalid_c6", bus.game_rvalid, 1);
            check("starve_game_rdata_c6", bus.game_rdata, 4'hF);
         end
      end
      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      disp_drive(1'b0, 5'd0, 4'd0);

      // Reset asserted the cycle after a read grant
      @(negedge clk);
      game_drive(1'b1, 1'b0, 5'd1, 4'd9, 4'h0);
      #1;
      check("rstrd_game_gnt", bus.game_gnt, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rstrd_game_rvalid", bus.game_rvalid, 0);
      check("rstrd_game_rdata", bus.game_rdata, 0);
      check("rstrd_game_gnt_low", bus.game_gnt, 0);
      check("rstrd_mem_rd", bus.mem_rd, 0);
      check("rstrd_mem_x", bus.mem_x, 0);
      check("rstrd_mem_y", bus.mem_y, 0);
      @(negedge clk);
      #1;
      check("rstrd_game_rvalid2", bus.game_rvalid, 0);

      // Grant available on the first edge after release
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rel_game_gnt", bus.game_gnt, 1);
      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      #1;
      check("rel_game_rvalid", bus.game_rvalid, 1);
      check("rel_game_rdata", bus.game_rdata, 4'h4);

`ifdef BOARD_ARB_CLEAR_EN
      // Seed (31,15)=RIGHT then wipe the board
      @(negedge clk);
      game_drive(1'b1, 1'b1, 5'd31, 4'd15, 4'h1);
      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      clear_start = 1'b1;
      #1;
      check("clr_busy_before_edge", clear_busy, 0);
      @(negedge clk);
      clear_start = 1'b0;
      game_drive(1'b1, 1'b0, 5'd31, 4'd15, 4'h0);
      disp_drive(1'b1, 5'd0, 4'd0);
      busy_cycles = 0;
      gnt_seen    = 0;
      done        = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         #1;
         if (clear_busy) begin
            busy_cycles++;
            if (bus.game_gnt || bus.disp_gnt) gnt_seen++;
            clear_start = (busy_cycles == 100);
            @(negedge clk);
         end else begin
            disp_drive(1'b0, 5'd0, 4'd0);
            done = 1'b1;
         end
      end
      check("clr_done", done, 1);
      check("clr_busy_cycles", busy_cycles, 512);
      check("clr_no_gnt", gnt_seen, 0);
      #1;
      check("clr_post_game_gnt", bus.game_gnt, 1);
      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      #1;
      check("clr_rvalid", bus.game_rvalid, 1);
      check("clr_rdata", bus.game_rdata, 4'h0);
`else
      // Without the wipe engine clear_start has no effect
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      #1;
      check("noclr_busy1", clear_busy, 0);
      game_drive(1'b1, 1'b0, 5'd3, 4'd9, 4'h0);
      #1;
      check("noclr_game_gnt", bus.game_gnt, 1);
      @(negedge clk);
      game_drive(1'b0, 1'b0, 5'd0, 4'd0, 4'h0);
      #1;
      check("noclr_busy2", clear_busy, 0);
      check("noclr_rdata", bus.game_rdata, 4'hF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
